scoreboard_display: RTL and testbench
=====================================

// Module: scoreboard_display
// PURPOSE
//  Drives the 4-digit multiplexed 7-segment display from the game top level, downstream of the countdown/score logic.
//  While the match countdown is running it shows the remaining seconds; once the countdown reaches 0 it shows "LL.RR" (player1.player2 scores).
//  Binary-to-BCD conversion is sequential (double-dabble), snapshotted once per scan frame.
// PARAMETERS
//  REFRESH_DIV  100_000     clk cycles per digit slot (1 ms @100 MHz); must be >= 32
//  FLASH_DIV    25_000_000  clk cycles per flash half-period (SCORE_FLASH_EN only)
// PORTS
//  clk        in   1  system clock, single clock domain
//  rst_n      in   1  asynchronous, active-low reset
//  time_left  in   8  countdown seconds, 0..255; 0 = match over
//  l_score    in   5  player1 score, 0..31
//  r_score    in   5  player2 score, 0..31
//  an         out  4  digit enables, active-low; an[0] = rightmost
//  seven      out  8  segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (async): an=4'b1111, seven=8'hFF, all digit regs = BLANK, FSM=IDLE, all counters 0, flash phase = ON.
//  Scan: scan_cnt counts 0..REFRESH_DIV-1; on wrap, idx advances 0->1->2->3->0. an = ~(4'b1 << idx); seven = glyph(digit[idx]), registered (1-cycle latency from idx).
//  Frame start = idx wraps 3->0. At frame start in IDLE: snapshot inputs; mode = SCORE if time_left==0, else COUNT.
//  FSM: IDLE -> CONV_A (8 shift cycles on snapshot A) -> [SCORE: CONV_B (8 cycles on B)] -> COMMIT -> IDLE.
//   COUNT: A=time_left.  SCORE: A={3'b0,l_score}, B={3'b0,r_score}.
//   COMMIT updates all 4 digit regs in one cycle; latency frame-start->commit = 10 cycles (COUNT) / 18 cycles (SCORE).
//   Frame start while FSM not IDLE: ignored (cannot occur with legal REFRESH_DIV). Input changes after snapshot are ignored until the next frame.
//  Digit map COUNT: d3=BLANK; d2=hundreds, BLANK if 0; d1=tens, BLANK if hundreds and tens both 0; d0=ones (always shown, including "0").
//  Digit map SCORE: d3=L tens, d2=L ones with dp lit, d1=R tens, d0=R ones; no zero blanking.
//  Glyphs: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 BLANK=FF; dp lit clears bit7.
//  The display never shows partial conversions; digits change only at COMMIT.
// CONFIGURATION
//  SCORE_FLASH_EN defined: in SCORE mode, flash_cnt counts to FLASH_DIV-1 and then toggles phase. Phase OFF forces an=4'b1111 (seven unchanged).
//   Entering SCORE mode (first COMMIT with mode=SCORE) clears flash_cnt and sets phase ON. COUNT mode: phase held ON.
//  SCORE_FLASH_EN undefined: no flash counter; the score display is steady.
// STRUCTURE
//  Package scoreboard_pkg: glyph constants (GLYPH_0..9, GLYPH_BLANK), BCD_BLANK=4'hF, FSM state enum, mode enum.
//  Sub-module bin2bcd_seq: 8-bit start/busy/done double-dabble -> 3 BCD nibbles, 8 cycles; instantiated once, reused for A and B.
//  Top holds scan counter, FSM, digit regs, glyph mux, and the optional flash logic.
// TESTING  (bench params REFRESH_DIV=32, FLASH_DIV=64)
//  1 rst_n=0 mid-scan -> an=1111, seven=FF on the same cycle; after release, first COMMIT no earlier than the first frame start.
//  2 time_left=180 -> after COMMIT: idx0 C0, idx1 80, idx2 F9, idx3 FF.
//  3 time_left=7 -> idx0 F8, idx1 FF, idx2 FF, idx3 FF; time_left=0 displays "0" only if mode is COUNT (n/a, since 0 selects SCORE).
//  4 time_left=0, l=12, r=5 -> idx3 F9, idx2 24 (2 with dp), idx1 C0, idx0 92; COMMIT exactly 18 cycles after frame start.
//  5 Change l_score during CONV_B -> the displayed value is the snapshot; the new value appears after the next frame's COMMIT.
//  6 SCORE_FLASH_EN, SCORE mode -> an alternates 64 cycles scanning / 64 cycles 1111; without the macro, an never goes all-1111 after reset.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the scoreboard display: segment glyphs,
// BCD blank code, FSM states and display modes.
package scoreboard_pkg;

    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV_A,
        ST_CONV_B,
        ST_COMMIT
    } state_t;

    typedef enum logic {
        MODE_COUNT,
        MODE_SCORE
    } mode_t;

    // Active-low segment pattern for one digit; a lit decimal point clears bit 7.
    function automatic logic [7:0] glyph(input logic [3:0] d, input logic dp);
        logic [7:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        if (dp) begin
            g[7] = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/scoreboard_display_bin2bcd.sv
// Sequential 8-bit double-dabble: one start pulse, eight shift cycles
// (the first on the start edge), then a one-cycle done pulse with bcd held.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [19:0] sr_reg;
    logic [2:0]  cnt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [11:0] adj;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (sr_reg[8 + gi*4 +: 4] >= 4'd5)
                                  ? sr_reg[8 + gi*4 +: 4] + 4'd3
                                  : sr_reg[8 + gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg   <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                // BCD field is all zero at load, so the first shift needs no adjust.
                sr_reg   <= {11'd0, bin, 1'b0};
                cnt_reg  <= 3'd1;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                sr_reg  <= {adj, sr_reg[7:0]} << 1;
                cnt_reg <= cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = sr_reg[19:8];

endmodule

// File: rtl/scoreboard_display.sv
// 4-digit multiplexed 7-segment driver: countdown seconds or "LL.RR" scores.
// Optional macro SCORE_FLASH_EN flashes the whole display in score mode.
module scoreboard_display
    import scoreboard_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int FLASH_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] time_left,
    input  logic [4:0] l_score,
    input  logic [4:0] r_score,
    output logic [3:0] an,
    output logic [7:0] seven
);

    localparam int SCAN_W = $clog2(REFRESH_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [1:0]        idx_reg;
    logic              frame_start;

    state_t      state_reg, state_next;
    mode_t       mode_reg;
    logic [7:0]  snap_a_reg, snap_b_reg;
    logic        kick_reg;
    logic [11:0] bcd_a_reg;
    logic [15:0] digit_reg;
    logic [3:0]  dp_reg;
    logic [3:0]  an_reg;
    logic [7:0]  seven_reg;

    logic        load_snap, capture_a, commit;
    logic        conv_start, conv_busy, conv_done;
    logic [7:0]  conv_bin;
    logic [11:0] conv_bcd;
    logic [15:0] digits_commit;
    logic [3:0]  dp_commit;
    logic        phase_on;

    assign frame_start = (scan_cnt_reg == SCAN_LAST) && (idx_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            idx_reg      <= 2'd0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            idx_reg      <= idx_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_snap  = 1'b0;
        capture_a  = 1'b0;
        commit     = 1'b0;
        conv_start = 1'b0;
        conv_bin   = snap_a_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start && !conv_busy) begin
                    load_snap  = 1'b1;
                    state_next = ST_CONV_A;
                end
            end
            ST_CONV_A: begin
                if (kick_reg) begin
                    conv_start = 1'b1;
                end else if (conv_done) begin
                    capture_a = 1'b1;
                    if (mode_reg == MODE_SCORE) begin
                        // Converter is reused back-to-back for the right score.
                        conv_start = 1'b1;
                        conv_bin   = snap_b_reg;
                        state_next = ST_CONV_B;
                    end else begin
                        state_next = ST_COMMIT;
                    end
                end
            end
            ST_CONV_B: begin
                if (conv_done) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg   <= MODE_COUNT;
            snap_a_reg <= '0;
            snap_b_reg <= '0;
            kick_reg   <= 1'b0;
            bcd_a_reg  <= '0;
        end else begin
            kick_reg <= load_snap;
            if (load_snap) begin
                if (time_left == 8'd0) begin
                    mode_reg   <= MODE_SCORE;
                    snap_a_reg <= {3'b000, l_score};
                end else begin
                    mode_reg   <= MODE_COUNT;
                    snap_a_reg <= time_left;
                end
                snap_b_reg <= {3'b000, r_score};
            end
            if (capture_a) begin
                bcd_a_reg <= conv_bcd;
            end
        end
    end

    // Digit layout {d3,d2,d1,d0}; countdown blanks leading zeros, scores never do.
    always_comb begin
        digits_commit = {4{BCD_BLANK}};
        dp_commit     = 4'b0000;
        if (mode_reg == MODE_SCORE) begin
            digits_commit = {bcd_a_reg[7:0], conv_bcd[7:0]};
            dp_commit     = 4'b0100;
        end else begin
            digits_commit[3:0]  = bcd_a_reg[3:0];
            digits_commit[7:4]  = (bcd_a_reg[11:4] == 8'd0) ? BCD_BLANK : bcd_a_reg[7:4];
            digits_commit[11:8] = (bcd_a_reg[11:8] == 4'd0) ? BCD_BLANK : bcd_a_reg[11:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_reg <= {4{BCD_BLANK}};
            dp_reg    <= 4'b0000;
        end else if (commit) begin
            digit_reg <= digits_commit;
            dp_reg    <= dp_commit;
        end
    end

`ifdef SCORE_FLASH_EN
    localparam int FLASH_W = $clog2(FLASH_DIV);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);

    logic [FLASH_W-1:0] flash_cnt_reg;
    logic               phase_on_reg;
    mode_t              disp_mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
            disp_mode_reg <= MODE_COUNT;
        end else begin
            if (commit) begin
                disp_mode_reg <= mode_reg;
            end
            if (commit && (mode_reg != disp_mode_reg)) begin
                flash_cnt_reg <= '0;
                phase_on_reg  <= 1'b1;
            end else if (disp_mode_reg == MODE_SCORE) begin
                if (flash_cnt_reg == FLASH_LAST) begin
                    flash_cnt_reg <= '0;
                    phase_on_reg  <= ~phase_on_reg;
                end else begin
                    flash_cnt_reg <= flash_cnt_reg + 1'b1;
                end
            end else begin
                flash_cnt_reg <= '0;
                phase_on_reg  <= 1'b1;
            end
        end
    end

    assign phase_on = phase_on_reg;
`else
    // Steady display: FLASH_DIV is always nonzero, so the phase stays on.
    assign phase_on = (FLASH_DIV != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg    <= 4'b1111;
            seven_reg <= GLYPH_BLANK;
        end else begin
            an_reg    <= phase_on ? ~(4'b0001 << idx_reg) : 4'b1111;
            seven_reg <= glyph(digit_reg[idx_reg*4 +: 4], dp_reg[idx_reg]);
        end
    end

    assign an    = an_reg;
    assign seven = seven_reg;

endmodule

// File: tb/tb_scoreboard_display.sv
// Directed bench for scoreboard_display (REFRESH_DIV=32, FLASH_DIV=64).
// Frame starts fall every 128 cycles after reset release.
module tb_scoreboard_display;

    localparam int RD    = 32;
    localparam int FD    = 64;
    localparam int FRAME = 4 * RD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] time_left;
    logic [4:0] l_score;
    logic [4:0] r_score;
    logic [3:0] an;
    logic [7:0] seven;

    scoreboard_display #(.REFRESH_DIV(RD), .FLASH_DIV(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .time_left (time_left),
        .l_score   (l_score),
        .r_score   (r_score),
        .an        (an),
        .seven     (seven)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  tl;
        logic [4:0]  l;
        logic [4:0]  r;
        logic [31:0] exp;   // {d3,d2,d1,d0} glyphs
    } vec_t;

    vec_t vecs [12];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    function automatic int next_frame();
        return ((cyc / FRAME) + 1) * FRAME;
    endfunction

    function automatic logic [3:0] exp_an(input int i, input logic score);
        logic [3:0] one;
        one = 4'b0001;
`ifdef SCORE_FLASH_EN
        if (score && i >= 2) return 4'b1111;
`endif
        return ~(one << i);
    endfunction

    initial begin
        int f;
        int off_cnt;
        logic [31:0] e;

        vecs[0]  = '{8'd180, 5'd0,  5'd0,  32'hFFF980C0};
        vecs[1]  = '{8'd7,   5'd0,  5'd0,  32'hFFFFFFF8};
        vecs[2]  = '{8'd205, 5'd0,  5'd0,  32'hFFA4C092};
        vecs[3]  = '{8'd255, 5'd0,  5'd0,  32'hFFA49292};
        vecs[4]  = '{8'd42,  5'd0,  5'd0,  32'hFFFF99A4};
        vecs[5]  = '{8'd1,   5'd0,  5'd0,  32'hFFFFFFF9};
        vecs[6]  = '{8'd0,   5'd12, 5'd5,  32'hF924C092};
        vecs[7]  = '{8'd0,   5'd31, 5'd0,  32'hB079C0C0};
        vecs[8]  = '{8'd0,   5'd9,  5'd23, 32'hC010A4B0};
        vecs[9]  = '{8'd0,   5'd0,  5'd0,  32'hC040C0C0};
        vecs[10] = '{8'd100, 5'd0,  5'd0,  32'hFFF9C0C0};
        vecs[11] = '{8'd10,  5'd0,  5'd0,  32'hFFFFF9C0};

        // Reset state and first-commit timing
        rst_n = 1'b0;
        time_left = 8'd7;
        l_score = 5'd0;
        r_score = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", {4'h0, an}, 8'h0F);
        check("reset_seven", seven, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        goto(20);
        check("boot_an", {4'h0, an}, 8'h0E);
        check("boot_seven_blank", seven, 8'hFF);
        goto(FRAME + 10);
        check("count_commit_pre", seven, 8'hFF);
        tick();
        check("count_commit_post", seven, 8'hF8);

        // Table of single-frame conversions
        for (int v = 0; v < 12; v++) begin
            time_left = vecs[v].tl;
            l_score   = vecs[v].l;
            r_score   = vecs[v].r;
            e         = vecs[v].exp;
            f         = next_frame();
            for (int i = 0; i < 4; i++) begin
                goto(f + RD * i + 20);
                check($sformatf("vec%0d_seven_d%0d", v, i), seven, e[8*i +: 8]);
                check($sformatf("vec%0d_an_d%0d", v, i), {4'h0, an},
                      {4'h0, exp_an(i, vecs[v].tl == 8'd0)});
            end
        end

        // Score commit latency: 18 cycles after frame start (d0 was "0")
        time_left = 8'd0;
        l_score   = 5'd12;
        r_score   = 5'd5;
        f = next_frame();
        goto(f + 18);
        check("score_lat_pre", seven, 8'hC0);
        tick();
        check("score_lat_post", seven, 8'h92);

        // Count commit latency: 10 cycles after frame start
        time_left = 8'd180;
        f = next_frame();
        goto(f + 10);
        check("count_lat_pre", seven, 8'h92);
        tick();
        check("count_lat_post", seven, 8'hC0);

        // Input change during CONV_B is ignored until the next frame
        time_left = 8'd0;
        l_score   = 5'd20;
        r_score   = 5'd7;
        f = next_frame();
        goto(f + 12);
        l_score = 5'd3;
        goto(f + 20);
        check("snap_d0", seven, 8'hF8);
        goto(f + 2 * RD + 20);
        check("snap_d2", seven, 8'h40);
        goto(f + 3 * RD + 20);
        check("snap_d3", seven, 8'hA4);
        f = f + FRAME;
        goto(f + 2 * RD + 20);
        check("next_frame_d2", seven, 8'h30);
        goto(f + 3 * RD + 20);
        check("next_frame_d3", seven, 8'hC0);

        // Flash behaviour in steady score mode over two flash periods
        off_cnt = 0;
        for (int k = 0; k < 4 * FD; k++) begin
            tick();
            if (an == 4'b1111) off_cnt++;
        end
`ifdef SCORE_FLASH_EN
        check("flash_off_cycles", off_cnt[7:0], 8'd128);
`else
        check("flash_off_cycles", off_cnt[7:0], 8'd0);
`endif

        // Mid-scan asynchronous reset
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_an", {4'h0, an}, 8'h0F);
        check("midreset_seven", seven, 8'hFF);
        time_left = 8'd42;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        goto(20);
        check("reboot_seven_blank", seven, 8'hFF);
        goto(FRAME + 10);
        check("reboot_commit_pre", seven, 8'hFF);
        tick();
        check("reboot_commit_post", seven, 8'hA4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
